// File: rtl/ahb_sram_slave.sv
// AHB-Lite responder backed by a word-addressed flop memory, with byte/halfword/word writes and two-cycle ERROR responses.
// Latency: data phase completes WAIT_STATES enabled cycles after accept (OKAY), or 2 cycles after accept (ERROR).
// Backpressure: h_readyout is held low during wait states and ERROR cycle 1; every state change requires h_clk_en=1.
//
// Ports:
//   clk, reset_n         clock, asynchronous active-low reset
//   h_clk_en             AHB clock enable; all state, counter and memory updates are gated by it
//   h_sel, h_addr, h_trans, h_write, h_size
//                        address-phase inputs; sampled when h_sel & h_ready & NONSEQ/SEQ
//   h_wdata              data-phase write data; used in the final (S_DONE) data-phase cycle
//   h_ready              bus HREADY
//   h_readyout, h_resp   registered slave ready / response
//   h_rdata              registered read data; nonzero only in the final cycle of a read
module ahb_sram_slave #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_STATES = 0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  h_clk_en,
    input  logic                  h_sel,
    input  logic [ADDR_WIDTH-1:0] h_addr,
    input  logic [1:0]            h_trans,
    input  logic                  h_write,
    input  logic [2:0]            h_size,
    input  logic [DATA_WIDTH-1:0] h_wdata,
    input  logic                  h_ready,
    output logic                  h_readyout,
    output logic                  h_resp,
    output logic [DATA_WIDTH-1:0] h_rdata
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam int NB    = DATA_WIDTH / 8;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WAIT = 3'd1,
        S_DONE = 3'd2,
        S_ERR1 = 3'd3,
        S_ERR2 = 3'd4
    } state_t;

    state_t                  state_q,    state_d;
    logic [3:0]              cnt_q,      cnt_d;
    logic [IDX_W-1:0]        idx_q,      idx_d;
    logic [1:0]              lane_q,     lane_d;
    logic [1:0]              size_q,     size_d;
    logic                    write_q,    write_d;
    logic                    readyout_q, readyout_d;
    logic                    resp_q,     resp_d;
    logic [DATA_WIDTH-1:0]   rdata_q,    rdata_d;

    // Contents are deliberately not reset.
    logic [DATA_WIDTH-1:0]   mem [DEPTH_WORDS];

    logic                    can_accept;
    logic                    accept;
    logic                    acc_err;
    logic [ADDR_WIDTH-3:0]   word_addr;
    logic                    oob;
    logic                    bad_size;
    logic                    misalign;
    logic [NB-1:0]           be;
    logic                    commit;
    logic [DATA_WIDTH-1:0]   wr_word;

    // Address-phase decode and error classification
    always_comb begin
        // The slave only samples a new address phase while it is driving ready high.
        can_accept = (state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERR2);
        accept     = can_accept && h_sel && h_ready && ((h_trans == 2'b10) || (h_trans == 2'b11));
        word_addr  = h_addr[ADDR_WIDTH-1:2];
        oob        = word_addr >= (ADDR_WIDTH-2)'(DEPTH_WORDS);
        bad_size   = h_size > 3'd2;
        misalign   = ((h_size == 3'd1) && h_addr[0]) ||
                     ((h_size == 3'd2) && (h_addr[1:0] != 2'b00));
        acc_err    = oob || bad_size || misalign;
    end

    // Write lane enables and merged write word for the transfer in its final cycle
    always_comb begin
        case (size_q)
            2'd0:    be = 4'b0001 << lane_q;
            2'd1:    be = lane_q[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        commit  = h_clk_en && (state_q == S_DONE) && write_q;
        wr_word = mem[idx_q];
        for (int i = 0; i < NB; i++) begin
            if (be[i]) begin
                wr_word[i*8 +: 8] = h_wdata[i*8 +: 8];
            end
        end
    end

    // Next-state, address-phase capture and registered outputs
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        lane_d  = lane_q;
        size_d  = size_q;
        write_d = write_q;

        case (state_q)
            S_IDLE, S_DONE, S_ERR2: begin
                if (accept) begin
                    idx_d   = h_addr[IDX_W+1:2];
                    lane_d  = h_addr[1:0];
                    size_d  = h_size[1:0];
                    write_d = h_write;
                    if (acc_err) begin
                        state_d = S_ERR1;
                    end else if (WAIT_STATES > 0) begin
                        state_d = S_WAIT;
                        cnt_d   = 4'(WAIT_STATES - 1);
                    end else begin
                        state_d = S_DONE;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_ERR1:  state_d = S_ERR2;
            default: state_d = S_IDLE;
        endcase

        readyout_d = !((state_d == S_WAIT) || (state_d == S_ERR1));
        resp_d     = (state_d == S_ERR1) || (state_d == S_ERR2);

        // A read entering S_DONE on the same edge a write to that word commits
        // must see the merged word, not the stale array entry.
        rdata_d = '0;
        if ((state_d == S_DONE) && !write_d) begin
            if (commit && (idx_q == idx_d)) begin
                rdata_d = wr_word;
            end else begin
                rdata_d = mem[idx_d];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= 4'd0;
            idx_q      <= '0;
            lane_q     <= 2'd0;
            size_q     <= 2'd0;
            write_q    <= 1'b0;
            readyout_q <= 1'b1;
            resp_q     <= 1'b0;
            rdata_q    <= '0;
        end else if (h_clk_en) begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            lane_q     <= lane_d;
            size_q     <= size_d;
            write_q    <= write_d;
            readyout_q <= readyout_d;
            resp_q     <= resp_d;
            rdata_q    <= rdata_d;
        end
    end

    // State is forced to S_IDLE while reset is low, so an aborted write never commits.
    always_ff @(posedge clk) begin
        if (commit) begin
            mem[idx_q] <= wr_word;
        end
    end

    assign h_readyout = readyout_q;
    assign h_resp     = resp_q;
    assign h_rdata    = rdata_q;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Self-checking bench: three responders (0, 2 and 3 wait states) on shared address/data inputs.
// Latency: each completion is checked against the wait count expected for that instance.
// Backpressure: each responder's h_readyout is looped back as its own h_ready.
module tb_ahb_sram_slave;

    localparam int ND = 3;

    logic                 clk = 1'b0;
    logic                 reset_n;
    logic                 h_clk_en;
    logic [ND-1:0]        h_sel;
    logic [31:0]          h_addr;
    logic [1:0]           h_trans;
    logic                 h_write;
    logic [2:0]           h_size;
    logic [31:0]          h_wdata;
    logic [ND-1:0]        h_readyout;
    logic [ND-1:0]        h_resp;
    logic [ND-1:0][31:0]  h_rdata;

    always #5 clk = ~clk;

    for (genvar g = 0; g < ND; g++) begin : g_dut
        ahb_sram_slave #(
            .ADDR_WIDTH (32),
            .DATA_WIDTH (32),
            .DEPTH_WORDS(256),
            .WAIT_STATES(g == 0 ? 0 : (g == 1 ? 2 : 3))
        ) u_dut (
            .clk       (clk),
            .reset_n   (reset_n),
            .h_clk_en  (h_clk_en),
            .h_sel     (h_sel[g]),
            .h_addr    (h_addr),
            .h_trans   (h_trans),
            .h_write   (h_write),
            .h_size    (h_size),
            .h_wdata   (h_wdata),
            .h_ready   (h_readyout[g]),
            .h_readyout(h_readyout[g]),
            .h_resp    (h_resp[g]),
            .h_rdata   (h_rdata[g])
        );
    end

    typedef struct {
        logic [31:0] addr;
        logic        write;
        logic [2:0]  size;
        logic [31:0] wdata;
    } req_t;

    typedef struct {
        logic        err;
        int          waits;
        logic        write;
        logic [31:0] rdata;
        logic [31:0] addr;
    } exp_t;

    req_t        req_q[$];
    exp_t        exp_q[$];
    logic [31:0] model_mem [ND][256];
    int          ws_of [ND] = '{0, 2, 3};
    int          errors = 0;
    int          checks = 0;

    // Queue one transfer and its expected completion, updating the reference memory.
    task automatic push_req(input int d, input logic [31:0] addr, input logic wr,
                            input logic [2:0] size, input logic [31:0] data);
        req_t        r;
        exp_t        e;
        logic [3:0]  lanes;
        logic [31:0] wd;
        logic [31:0] word;
        int          idx;
        e.err   = (addr[31:2] >= 30'd256) || (size > 3'd2) ||
                  ((size == 3'd1) && addr[0]) || ((size == 3'd2) && (addr[1:0] != 2'b00));
        e.waits = e.err ? 1 : ws_of[d];
        e.write = wr;
        e.addr  = addr;
        e.rdata = '0;
        wd      = $urandom;
        case (size)
            3'd0: begin
                lanes = 4'b0001 << addr[1:0];
                wd[addr[1:0]*8 +: 8] = data[7:0];
            end
            3'd1: begin
                lanes = addr[1] ? 4'b1100 : 4'b0011;
                wd[addr[1]*16 +: 16] = data[15:0];
            end
            default: begin
                lanes = 4'b1111;
                wd    = data;
            end
        endcase
        if (!e.err) begin
            idx  = int'(addr[9:2]);
            word = model_mem[d][idx];
            if (wr) begin
                for (int i = 0; i < 4; i++) begin
                    if (lanes[i]) word[i*8 +: 8] = wd[i*8 +: 8];
                end
                model_mem[d][idx] = word;
            end else begin
                e.rdata = word;
            end
        end
        r.addr  = addr;
        r.write = wr;
        r.size  = size;
        r.wdata = wd;
        req_q.push_back(r);
        exp_q.push_back(e);
    endtask

    // Drive queued transfers pipelined to responder d and score each completion.
    task automatic run_seq(input int d);
        req_t        dp;
        req_t        nx;
        exp_t        e;
        logic        dp_vld;
        logic        nx_vld;
        logic        stall_bad;
        logic        ro;
        logic        rs;
        logic [31:0] rd;
        int          waits;
        int          cyc;
        dp_vld    = 1'b0;
        stall_bad = 1'b0;
        waits     = 0;
        cyc       = 0;
        h_sel     = 3'(1 << d);
        while (((req_q.size() > 0) || dp_vld) && (cyc < 400)) begin
            @(negedge clk);
            cyc++;
            ro = h_readyout[d];
            rs = h_resp[d];
            rd = h_rdata[d];
            if (dp_vld) begin
                if (dp.write) h_wdata = dp.wdata;
                if (!ro) begin
                    waits++;
                    if ((rs !== exp_q[0].err) || (rd !== 32'h0)) stall_bad = 1'b1;
                end else begin
                    e = exp_q.pop_front();
                    checks++;
                    if (rs !== e.err) begin
                        errors++;
                        $display("FAIL resp dut%0d addr=%h: got %b want %b", d, e.addr, rs, e.err);
                    end
                    checks++;
                    if ((waits !== e.waits) || stall_bad) begin
                        errors++;
                        $display("FAIL stall dut%0d addr=%h: waits %0d want %0d, stall outputs bad=%b",
                                 d, e.addr, waits, e.waits, stall_bad);
                    end
                    if (!e.write || e.err) begin
                        checks++;
                        if (rd !== e.rdata) begin
                            errors++;
                            $display("FAIL rdata dut%0d addr=%h: got %h want %h", d, e.addr, rd, e.rdata);
                        end
                    end
                    dp_vld    = 1'b0;
                    waits     = 0;
                    stall_bad = 1'b0;
                end
            end
            nx_vld = 1'b0;
            if (ro && (req_q.size() > 0)) begin
                nx      = req_q.pop_front();
                nx_vld  = 1'b1;
                h_trans = 2'b10;
                h_addr  = nx.addr;
                h_write = nx.write;
                h_size  = nx.size;
            end else begin
                h_trans = 2'b00;
            end
            @(posedge clk);
            if (nx_vld) begin
                dp     = nx;
                dp_vld = 1'b1;
            end
        end
        if (dp_vld || (req_q.size() > 0)) begin
            checks++;
            errors++;
            $display("FAIL timeout dut%0d: %0d transfers outstanding", d, exp_q.size());
            req_q.delete();
            exp_q.delete();
        end
        @(negedge clk);
        h_trans = 2'b00;
        h_sel   = '0;
    endtask

    task automatic test_reset();
        reset_n  = 1'b0;
        h_clk_en = 1'b1;
        h_sel    = '0;
        h_addr   = '0;
        h_trans  = 2'b00;
        h_write  = 1'b0;
        h_size   = 3'd0;
        h_wdata  = '0;
        repeat (3) @(negedge clk);
        for (int d = 0; d < ND; d++) begin
            checks++;
            if ({h_readyout[d], h_resp[d], h_rdata[d]} !== {1'b1, 1'b0, 32'h0}) begin
                errors++;
                $display("FAIL reset dut%0d: ready=%b resp=%b rdata=%h want 1 0 0",
                         d, h_readyout[d], h_resp[d], h_rdata[d]);
            end
        end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        push_req(0, 32'h10, 1'b1, 3'd2, 32'hDEADBEEF);
        push_req(0, 32'h10, 1'b0, 3'd2, 32'h0);
        run_seq(0);
    endtask

    task automatic test_wait_states();
        push_req(1, 32'h10, 1'b1, 3'd2, 32'hDEADBEEF);
        push_req(1, 32'h10, 1'b0, 3'd2, 32'h0);
        push_req(1, 32'h10, 1'b0, 3'd0, 32'h0);
        run_seq(1);
    endtask

    task automatic test_byte_lanes();
        push_req(0, 32'h11, 1'b1, 3'd0, 32'h000000AA);
        push_req(0, 32'h12, 1'b1, 3'd1, 32'h00001234);
        push_req(0, 32'h10, 1'b0, 3'd2, 32'h0);
        push_req(0, 32'h14, 1'b1, 3'd1, 32'h0000BEEF);
        push_req(0, 32'h17, 1'b1, 3'd0, 32'h00000055);
        push_req(0, 32'h14, 1'b0, 3'd1, 32'h0);
        run_seq(0);
    endtask

    task automatic test_errors();
        push_req(0, 32'h00,  1'b1, 3'd2, 32'h01234567);
        push_req(0, 32'h400, 1'b1, 3'd2, 32'hFFFFFFFF);
        push_req(0, 32'h02,  1'b1, 3'd2, 32'hFFFFFFFF);
        push_req(0, 32'h13,  1'b1, 3'd1, 32'hFFFFFFFF);
        push_req(0, 32'h10,  1'b1, 3'd3, 32'hFFFFFFFF);
        push_req(0, 32'h00,  1'b0, 3'd2, 32'h0);
        push_req(0, 32'h10,  1'b0, 3'd2, 32'h0);
        push_req(0, 32'h3FC, 1'b1, 3'd2, 32'hA5A50F0F);
        push_req(0, 32'h3FC, 1'b0, 3'd2, 32'h0);
        run_seq(0);
        push_req(1, 32'h400, 1'b0, 3'd2, 32'h0);
        push_req(1, 32'h12,  1'b1, 3'd2, 32'hFFFFFFFF);
        push_req(1, 32'h10,  1'b0, 3'd2, 32'h0);
        run_seq(1);
    endtask

    task automatic test_random();
        logic [31:0] a;
        for (int d = 0; d < 2; d++) begin
            for (int w = 0; w < 8; w++) push_req(d, 32'(w * 4), 1'b1, 3'd2, $urandom);
            for (int n = 0; n < 40; n++) begin
                a = 32'($urandom_range(0, 31));
                if ($urandom_range(0, 7) == 0) a = 32'h400 + 32'($urandom_range(0, 15));
                push_req(d, a, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 3)), $urandom);
            end
            run_seq(d);
        end
    endtask

    task automatic test_clk_en();
        logic        ro, rs, pro, prs, cur_en, prev_en, done;
        logic [31:0] rd, prd;
        int          en_waits;
        push_req(2, 32'h10, 1'b1, 3'd2, 32'h5A5AC3C3);
        run_seq(2);
        h_sel = 3'b100;
        @(negedge clk);
        h_clk_en = 1'b1;
        h_trans  = 2'b10;
        h_addr   = 32'h10;
        h_write  = 1'b0;
        h_size   = 3'd2;
        @(posedge clk);
        en_waits = 0;
        done     = 1'b0;
        prev_en  = 1'b1;
        pro      = 1'b0;
        prs      = 1'b0;
        prd      = '0;
        for (int k = 1; (k <= 30) && !done; k++) begin
            @(negedge clk);
            h_trans = 2'b00;
            ro = h_readyout[2];
            rs = h_resp[2];
            rd = h_rdata[2];
            if (!prev_en) begin
                checks++;
                if ({ro, rs, rd} !== {pro, prs, prd}) begin
                    errors++;
                    $display("FAIL frozen cycle %0d: %b %b %h want %b %b %h", k, ro, rs, rd, pro, prs, prd);
                end
            end
            if (ro) begin
                checks++;
                if (en_waits !== 3) begin
                    errors++;
                    $display("FAIL clk_en waits: got %0d want 3", en_waits);
                end
                checks++;
                if ({rs, rd} !== {1'b0, model_mem[2][4]}) begin
                    errors++;
                    $display("FAIL clk_en data: resp=%b rdata=%h want 0 %h", rs, rd, model_mem[2][4]);
                end
                done   = 1'b1;
                cur_en = 1'b1;
            end else begin
                cur_en = ((k % 2) == 0);
                if (cur_en) en_waits++;
            end
            h_clk_en = cur_en;
            prev_en  = cur_en;
            pro      = ro;
            prs      = rs;
            prd      = rd;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL clk_en timeout: no completion");
        end
        @(negedge clk);
        h_clk_en = 1'b1;
        h_sel    = '0;
    endtask

    task automatic test_reset_mid();
        push_req(1, 32'h20, 1'b1, 3'd2, 32'h11112222);
        run_seq(1);
        h_sel = 3'b010;
        @(negedge clk);
        h_trans = 2'b10;
        h_addr  = 32'h20;
        h_write = 1'b1;
        h_size  = 3'd2;
        @(posedge clk);
        @(negedge clk);
        h_trans = 2'b00;
        h_wdata = 32'hCAFEF00D;
        checks++;
        if (h_readyout[1] !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid stall: ready=%b want 0", h_readyout[1]);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if ({h_readyout[1], h_resp[1], h_rdata[1]} !== {1'b1, 1'b0, 32'h0}) begin
            errors++;
            $display("FAIL reset_mid outputs: ready=%b resp=%b rdata=%h want 1 0 0",
                     h_readyout[1], h_resp[1], h_rdata[1]);
        end
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        h_sel   = '0;
        @(negedge clk);
        push_req(1, 32'h20, 1'b0, 3'd2, 32'h0);
        run_seq(1);
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_wait_states();
        test_byte_lanes();
        test_errors();
        test_clk_en();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
